alu_step_sequencer: RTL

Parametrised control-step sequencer that drives the datapath's bus-enable and register-load strobes through fetch (T0–T2) and execute (T3–T6) for register-register ALU, unary, and multi-cycle MUL/DIV instructions. It replaces the hand-scheduled T-state stimulus with synthesizable control. It adds:
- a memory-ready handshake,
- a wait on multi-cycle ALU completion,
- HI/LO writeback,
- illegal-opcode detection,
- a run/halt control at instruction boundaries.

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/alu_step_sequencer_seq_decode.sv | 43 ++++
 rtl/alu_step_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU control-step sequencer:
// state and op-class enums, opcode values and IR field positions.
package alu_seq_pkg;

  localparam int FIELD_W = 4;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  // The encoding is exported on the step output, so it is fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_T6   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_BIN = 2'd0,
    CLS_UN  = 2'd1,
    CLS_MD  = 2'd2,
    CLS_ILL = 2'd3
  } op_class_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_SHRA = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/alu_step_sequencer_seq_decode.sv
// Combinational instruction decode: opcode to op class, and 4-bit register
// fields to one-hot enables (fields at or above NREG select nothing).
module seq_decode
  import alu_seq_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0]   i_opcode,
  input  logic [FIELD_W-1:0] i_ra,
  input  logic [FIELD_W-1:0] i_rb,
  input  logic [FIELD_W-1:0] i_rc,
  output op_class_e          o_class,
  output logic [NREG-1:0]    o_ra_oh,
  output logic [NREG-1:0]    o_rb_oh,
  output logic [NREG-1:0]    o_rc_oh
);

  function automatic logic [NREG-1:0] onehot(input logic [FIELD_W-1:0] f);
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) begin
      v[i] = (32'(f) == i);
    end
    return v;
  endfunction

  // Opcode classification; anything unlisted is illegal.
  always_comb begin
    case (i_opcode)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND), OPC_W'(OP_OR),
      OPC_W'(OP_ROR), OPC_W'(OP_ROL), OPC_W'(OP_SHR), OPC_W'(OP_SHL),
      OPC_W'(OP_SHRA):                 o_class = CLS_BIN;
      OPC_W'(OP_NEG), OPC_W'(OP_NOT):  o_class = CLS_UN;
      OPC_W'(OP_MUL), OPC_W'(OP_DIV):  o_class = CLS_MD;
      default:                         o_class = CLS_ILL;
    endcase
  end

  assign o_ra_oh = onehot(i_ra);
  assign o_rb_oh = onehot(i_rb);
  assign o_rc_oh = onehot(i_rc);

endmodule

// File: rtl/alu_step_sequencer.sv
// Fetch/execute control-step sequencer: walks T0..T6 and decodes the datapath
// bus-drive and register-load strobes from the current step and handshakes.
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              halt_req,
  input  logic [DATA_W-1:0] ir,
  input  logic              mem_ready,
  input  logic              alu_done,
  output logic              pc_out,
  output logic              zlo_out,
  output logic              zhi_out,
  output logic              mdr_out,
  output logic              mar_in,
  output logic              pc_in,
  output logic              mdr_in,
  output logic              ir_in,
  output logic              y_in,
  output logic              z_in,
  output logic              hi_in,
  output logic              lo_in,
  output logic              inc_pc,
  output logic              read,
  output logic [NREG-1:0]   rout,
  output logic [NREG-1:0]   rin,
  output logic [OPC_W-1:0]  alu_op,
  output logic              busy,
  output logic              illegal,
  output logic [2:0]        step
);

  state_e            r_state;
  logic              r_run;
  logic              w_run_next;
  state_e            w_eoi_state;
  logic [OPC_W-1:0]  w_opcode;
  op_class_e         w_class;
  logic [NREG-1:0]   w_ra_oh;
  logic [NREG-1:0]   w_rb_oh;
  logic [NREG-1:0]   w_rc_oh;
  logic              w_unused;

  assign w_opcode = ir[DATA_W-1 -: OPC_W];
  assign w_unused = ^ir[RC_LSB-1:0];

  seq_decode #(
    .NREG  (NREG),
    .OPC_W (OPC_W)
  ) u_decode (
    .i_opcode (w_opcode),
    .i_ra     (ir[RA_LSB +: FIELD_W]),
    .i_rb     (ir[RB_LSB +: FIELD_W]),
    .i_rc     (ir[RC_LSB +: FIELD_W]),
    .o_class  (w_class),
    .o_ra_oh  (w_ra_oh),
    .o_rb_oh  (w_rb_oh),
    .o_rc_oh  (w_rc_oh)
  );

  // start beats halt_req; the instruction boundary sees this cycle's request.
  assign w_run_next  = start ? 1'b1 : (halt_req ? 1'b0 : r_run);
  assign w_eoi_state = w_run_next ? ST_T0 : ST_IDLE;

  // Step sequencing and run flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_run <= w_run_next;
      case (r_state)
        ST_IDLE: r_state <= start ? ST_T0 : ST_IDLE;
        ST_T0:   r_state <= ST_T1;
        ST_T1:   r_state <= mem_ready ? ST_T2 : ST_T1;
        ST_T2:   r_state <= ST_T3;
        ST_T3: begin
          case (w_class)
            CLS_BIN, CLS_MD: r_state <= ST_T4;
            CLS_UN:          r_state <= ST_T5;
            default:         r_state <= w_eoi_state;
          endcase
        end
        ST_T4: begin
          if (w_class == CLS_MD && !alu_done) r_state <= ST_T4;
          else                                r_state <= ST_T5;
        end
        ST_T5:   r_state <= (w_class == CLS_MD) ? ST_T6 : w_eoi_state;
        ST_T6:   r_state <= w_eoi_state;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobe decode from the current step and the two handshakes.
  always_comb begin
    pc_out  = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    mdr_out = 1'b0;
    mar_in  = 1'b0;
    pc_in   = 1'b0;
    mdr_in  = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    illegal = 1'b0;
    rout    = '0;
    rin     = '0;
    alu_op  = '0;
    case (r_state)
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        zlo_out = 1'b1;
        read    = 1'b1;
        pc_in   = mem_ready;
        mdr_in  = mem_ready;
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      ST_T3: begin
        if (w_class == CLS_ILL) begin
          illegal = 1'b1;
        end else begin
          rout   = w_rb_oh;
          alu_op = w_opcode;
          y_in   = (w_class != CLS_UN);
          z_in   = (w_class == CLS_UN);
        end
      end
      ST_T4: begin
        rout   = w_rc_oh;
        alu_op = w_opcode;
        z_in   = (w_class == CLS_MD) ? alu_done : 1'b1;
      end
      ST_T5: begin
        zlo_out = 1'b1;
        if (w_class == CLS_MD) lo_in = 1'b1;
        else                   rin   = w_ra_oh;
      end
      ST_T6: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      default: begin
        pc_out = 1'b0;
      end
    endcase
  end

  assign busy = (r_state != ST_IDLE);
  assign step = r_state;

endmodule
